// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the binary_to_gray_counter and gray_to_binary users.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] word_t;

    // Action selected for the counter on a clock edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_STEP = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    // Binary to reflected Gray code.
    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix xor from the msb down).
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = g;
        for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    // True when exactly one bit differs between two codes.
    function automatic logic one_bit_change(input word_t a, input word_t b);
        word_t d;
        d = a ^ b;
        return (d != '0) && ((d & (d - word_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Purely combinational WIDTH-bit binary to Gray encoder, built as an xor chain.
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // The msb passes through; every lower bit is the xor of itself and its upper neighbour.
    assign gray[WIDTH-1] = bin[WIDTH-1];

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_xor
        assign gray[i] = bin[i+1] ^ bin[i];
    end

endmodule

// File: rtl/binary_to_gray_counter.sv
// Up/down binary counter with registered Gray output and a registered wrap pulse.
// Both codes are encoded from the next binary value so they update on the same edge.
module binary_to_gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

    op_e              op;
    logic [WIDTH-1:0] bin_step;
    logic             step_wraps;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Resolve the synchronous controls into one action: clr > load > en > hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end
    end

    // Next binary value, the +/-1 step (modulo 2^WIDTH) and its wrap detect.
    always_comb begin
        bin_step   = up_dn ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
        step_wraps = up_dn ? (bin_out == '1) : (bin_out == '0);
        bin_next   = bin_out;
        wrap_next  = 1'b0;
        unique case (op)
            OP_CLR:  bin_next = '0;
            OP_LOAD: bin_next = load_bin;
            OP_STEP: begin
                bin_next  = bin_step;
                wrap_next = step_wraps;
            end
            default: bin_next = bin_out;
        endcase
    end

    bin_to_gray #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // Output registers; reset is asynchronous and kills any pending wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out  <= RESET_BIN;
            gray_out <= RESET_GRAY;
            wrap     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all three flops sample the same pre-edge values.
            bin_out  <= bin_next;
            gray_out <= gray_next;
            wrap     <= wrap_next;
        end
    end

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Self-checking bench for binary_to_gray_counter (WIDTH=4) with a RESET_VAL=6 companion.
module tb_binary_to_gray_counter;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en, up_dn;
    logic [3:0] load_bin;
    logic [3:0] bin_out, gray_out;
    logic       wrap;
    logic [3:0] bin6, gray6;
    logic       wrap6;

    int checks   = 0;
    int failures = 0;

    binary_to_gray_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
        .en(en), .up_dn(up_dn), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
    );

    binary_to_gray_counter #(.WIDTH(4), .RESET_VAL(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
        .en(en), .up_dn(up_dn), .bin_out(bin6), .gray_out(gray6), .wrap(wrap6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] load_bin;
        logic       en;
        logic       up_dn;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    // Reference Gray table built by reflection, independent of any xor formula.
    int gray_tab[16];
    int model_bin;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] lb,
                         input logic e, input logic u);
        clr = c; load = l; load_bin = lb; en = e; up_dn = u;
    endtask

    function automatic void add(input logic c, input logic l, input logic [3:0] lb,
                                input logic e, input logic u, input logic [3:0] b,
                                input logic [3:0] g, input logic w);
        vec_t v;
        v.clr = c; v.load = l; v.load_bin = lb; v.en = e; v.up_dn = u;
        v.exp_bin = b; v.exp_gray = g; v.exp_wrap = w;
        vecs.push_back(v);
    endfunction

    initial begin
        int gseq[16];
        int n;
        logic [3:0] prev_gray;
        logic c, l, e, u;
        logic [3:0] lb;
        int exp_wrap;

        // Reflected-code construction: mirror the list and set the next bit on the copy.
        gray_tab[0] = 0;
        n = 1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < n; i++) gray_tab[n + i] = gray_tab[n - 1 - i] | (1 << b);
            n = n * 2;
        end

        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        // Count up through all 16 codes, wrap on F->0.
        for (int k = 1; k <= 16; k++)
            add(0, 0, 4'h0, 1, 1, 4'(k % 16), 4'(gseq[k % 16]), (k == 16));
        // Down step from 0 wraps to F, then a plain down step to E.
        add(0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1);
        add(0, 0, 4'h0, 1, 0, 4'hE, 4'h9, 0);
        // Load, then clr beating load and en.
        add(0, 1, 4'h5, 0, 0, 4'h5, 4'h7, 0);
        add(1, 1, 4'h9, 1, 1, 4'h0, 4'h0, 0);
        // Park at A, then hold for 10 cycles with up_dn toggling.
        add(0, 1, 4'hA, 0, 1, 4'hA, 4'hF, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 4'h3, 0, k[0], 4'hA, 4'hF, 0);
        // Load beats en; then up wrap; then the pulse clears.
        add(0, 1, 4'hF, 1, 0, 4'hF, 4'h8, 0);
        add(0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1);
        add(0, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0);
        // Direction change between consecutive steps.
        add(0, 0, 4'h0, 1, 1, 4'h1, 4'h1, 0);
        add(0, 0, 4'h0, 1, 0, 4'h0, 4'h0, 0);
        add(0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1);
        add(0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1);

        // Reset state for both instances.
        rst_n = 1'b0;
        drive(0, 0, 4'h0, 0, 1);
        step();
        step();
        check("rst_bin", bin_out, 0);
        check("rst_gray", gray_out, 0);
        check("rst_wrap", wrap, 0);
        check("rst6_bin", bin6, 6);
        check("rst6_gray", gray6, 5);
        check("rst6_wrap", wrap6, 0);
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            prev_gray = gray_out;
            drive(vecs[i].clr, vecs[i].load, vecs[i].load_bin, vecs[i].en, vecs[i].up_dn);
            step();
            check($sformatf("vec%0d_bin", i), bin_out, vecs[i].exp_bin);
            check($sformatf("vec%0d_gray", i), gray_out, vecs[i].exp_gray);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
            if (vecs[i].en && !vecs[i].clr && !vecs[i].load)
                check($sformatf("vec%0d_onebit", i), one_bit_change(word_t'(prev_gray), word_t'(gray_out)), 1);
        end

        // Asynchronous reset mid-cycle at bin=C.
        drive(0, 1, 4'hC, 0, 1);
        step();
        check("at_c_bin", bin_out, 4'hC);
        drive(0, 0, 4'h0, 1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_bin", bin_out, 0);
        check("async_gray", gray_out, 0);
        check("async_wrap", wrap, 0);
        check("async6_gray", gray6, 5);
        step();
        check("hold_in_rst_bin", bin_out, 0);
        check("hold_in_rst6_bin", bin6, 6);
        rst_n = 1'b1;

        // Async reset kills a pending wrap pulse.
        drive(0, 1, 4'hF, 0, 1);
        step();
        drive(0, 0, 4'h0, 1, 1);
        step();
        check("prekill_wrap", wrap, 1);
        drive(0, 0, 4'h0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("kill_wrap", wrap, 0);
        check("kill_bin", bin_out, 0);
        step();
        rst_n = 1'b1;

        // First edge after release counts.
        drive(0, 0, 4'h0, 1, 1);
        step();
        check("release_bin", bin_out, 1);
        model_bin = 1;

        // Randomized run against an arithmetic model.
        for (int k = 0; k < 10000; k++) begin
            c  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 15) == 0);
            lb = 4'($urandom_range(0, 15));
            e  = 1'($urandom);
            u  = 1'($urandom);
            exp_wrap = 0;
            if (c) begin
                model_bin = 0;
            end else if (l) begin
                model_bin = int'(lb);
            end else if (e) begin
                if (u && model_bin == 15) exp_wrap = 1;
                if (!u && model_bin == 0) exp_wrap = 1;
                model_bin = (model_bin + (u ? 1 : 15)) % 16;
            end
            prev_gray = gray_out;
            drive(c, l, lb, e, u);
            step();
            check("rand_bin", bin_out, model_bin);
            check("rand_gray", gray_out, gray_tab[model_bin]);
            check("rand_wrap", wrap, exp_wrap);
            if (e && !c && !l)
                check("rand_onebit", one_bit_change(word_t'(prev_gray), word_t'(gray_out)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
